maxpool_relu_stream: RTL and testbench

MAXPOOL_RELU_STREAM -- requirements
Module: maxpool_relu_stream

---
 rtl/maxpool_relu_stream.sv | 125 ++++++++++++
 tb/tb_maxpool_relu_stream.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/maxpool_relu_stream.sv
// 2x2 stride-2 max pooling followed by ReLU over a raster stream of K feature maps.
// Horizontal pairs are reduced on the fly; row maxima wait in a half-width line buffer.
module maxpool_relu_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_H       = 6,
  parameter int IN_W       = 6,
  parameter int K          = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  map_done,
  output logic                  frame_done
);

  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);
  localparam int MW = (K > 1) ? $clog2(K) : 1;
  localparam int LB = IN_W / 2;
  localparam int HW = (LB > 1) ? $clog2(LB) : 1;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [MW-1:0]         map_q, map_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic [DATA_WIDTH-1:0] lbuf_q [LB];
  logic [DATA_WIDTH-1:0] lbuf_d [LB];
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  map_done_q, map_done_d;
  logic                  frame_done_q, frame_done_d;

  logic                  in_xfer, out_xfer, load;
  logic                  col_last, row_last, map_last;
  logic [HW-1:0]         half;
  logic [DATA_WIDTH-1:0] hmax, vmax;

  always_comb begin
    in_ready = (!out_valid_q || out_ready) && !frame_done_q;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid_q && out_ready;
    col_last = (col_q == CW'(IN_W - 1));
    row_last = (row_q == RW'(IN_H - 1));
    map_last = (map_q == MW'(K - 1));
    half     = HW'(col_q >> 1);
    hmax     = ($signed(pair_q) >= $signed(in_data)) ? pair_q : in_data;
    vmax     = ($signed(lbuf_q[half]) >= $signed(hmax)) ? lbuf_q[half] : hmax;
    // A window completes on the odd-row, odd-column pixel.
    load     = in_xfer && col_q[0] && row_q[0];

    col_d        = col_q;
    row_d        = row_q;
    map_d        = map_q;
    pair_d       = pair_q;
    lbuf_d       = lbuf_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;

    if (in_xfer) begin
      if (!col_q[0]) begin
        pair_d = in_data;
      end else if (!row_q[0]) begin
        lbuf_d[half] = hmax;
      end

      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d = '0;
          map_d = map_last ? '0 : map_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A fresh result wins over the drain of the previous one.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = vmax[DATA_WIDTH-1] ? '0 : vmax;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    map_done_d   = load && col_last && row_last;
    frame_done_d = frame_done_q || (map_done_d && map_last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      map_q        <= '0;
      pair_q       <= '0;
      for (int i = 0; i < LB; i++) lbuf_q[i] <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      map_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      map_q        <= map_d;
      pair_q       <= pair_d;
      lbuf_q       <= lbuf_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      map_done_q   <= map_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign map_done   = map_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// Bench for maxpool_relu_stream: a pixel-index model predicts every output cycle by cycle
// from the frame contents; directed frames plus randomized data and handshakes.
module tb_maxpool_relu_stream;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int KM = 6;
  localparam int MP = W * H;
  localparam int NP = KM * MP;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       map_done;
  logic       frame_done;

  maxpool_relu_stream #(.DATA_WIDTH(8), .IN_H(H), .IN_W(W), .K(KM)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .map_done(map_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pix [NP];
  int m_ov, m_od, m_md, m_fd, m_acc;
  int obs_q [$];
  int md_cnt;
  int ramp_exp [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Max of the 2x2 window whose bottom-right pixel is idx, then ReLU.
  function automatic int pool(input int idx);
    int m;
    m = pix[idx];
    if (pix[idx-1] > m) m = pix[idx-1];
    if (pix[idx-W] > m) m = pix[idx-W];
    if (pix[idx-W-1] > m) m = pix[idx-W-1];
    return (m < 0) ? 0 : m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_map_done", map_done, 0);
    chk("rst_frame_done", frame_done, 0);
    m_ov = 0; m_od = 0; m_md = 0; m_fd = 0; m_acc = 0;
    obs_q.delete();
    md_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // mode 0: always ready; 1: random valid/ready; 2: output stall after first result; 3: push after frame
  task automatic run(input int npix, input int mode, input bit drain, input int min_cyc);
    int cyc;
    bit iv, ordy, erdy, inx, outx, ld;
    int idx, mp, r, c;
    cyc = 0;
    while (m_acc < npix || (drain && m_ov != 0) || cyc < min_cyc) begin
      if (cyc >= 5000) begin
        vectors++;
        miscompares++;
        $error("FAIL run_timeout: observed %0d accepted expected %0d", m_acc, npix);
        break;
      end
      @(negedge clk);
      if (m_acc < npix) iv = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      else iv = (mode == 3);
      case (mode)
        1:       ordy = ($urandom_range(0, 2) != 0);
        2:       ordy = !(cyc >= 8 && cyc < 26);
        default: ordy = 1'b1;
      endcase
      in_valid  = iv;
      in_data   = (iv && m_acc < NP) ? 8'(pix[m_acc]) : 8'($urandom);
      out_ready = ordy;
      #1;
      erdy = (m_ov == 0 || ordy) && m_fd == 0;
      chk("in_ready", in_ready, erdy);
      chk("out_valid", out_valid, m_ov);
      if (m_ov != 0) chk("out_data", out_data, m_od);
      chk("map_done", map_done, m_md);
      chk("frame_done", frame_done, m_fd);
      if (out_valid && ordy) obs_q.push_back(int'(out_data));
      if (map_done) md_cnt++;

      inx  = iv && erdy;
      outx = (m_ov != 0) && ordy;
      ld   = 0;
      m_md = 0;
      if (inx) begin
        idx = m_acc;
        mp  = idx / MP;
        r   = (idx % MP) / W;
        c   = idx % W;
        if (r % 2 == 1 && c % 2 == 1) begin
          ld   = 1;
          m_od = pool(idx);
          if (r == H - 1 && c == W - 1) begin
            m_md = 1;
            if (mp == KM - 1) m_fd = 1;
          end
        end
        m_acc++;
      end
      m_ov = ld ? 1 : (outx ? 0 : m_ov);
      cyc++;
    end
  endtask

  task automatic check_ramp(input string tag);
    chk({tag, "_count"}, obs_q.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < obs_q.size()) chk(tag, obs_q[i], ramp_exp[i]);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // Ramp map, continuous flow.
    do_reset();
    for (int i = 0; i < NP; i++) pix[i] = (i < MP) ? i : 0;
    run(MP, 0, 1'b1, 0);
    check_ramp("ramp_out");
    chk("ramp_map_done_cnt", md_cnt, 1);

    // Negative saturation, equal operands, most-negative value.
    do_reset();
    for (int i = 0; i < NP; i++) pix[i] = (i < MP) ? -5 : -128;
    pix[MP + W + 1] = 1;
    run(2 * MP, 0, 1'b1, 0);
    chk("neg_count", obs_q.size(), 18);
    for (int i = 0; i < 18; i++)
      if (i < obs_q.size()) chk("neg_out", obs_q[i], (i == 9) ? 1 : 0);
    chk("neg_map_done_cnt", md_cnt, 2);

    // Output stall while the first result is held.
    do_reset();
    for (int i = 0; i < NP; i++) pix[i] = (i < MP) ? i : 0;
    run(MP, 2, 1'b1, 0);
    check_ramp("stall_out");

    // Ramp with random handshakes.
    do_reset();
    run(MP, 1, 1'b1, 0);
    check_ramp("rand_hs_out");

    // Full frame of random data with random handshakes, then refused pushes.
    do_reset();
    for (int i = 0; i < NP; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
    run(NP, 1, 1'b1, 0);
    chk("frame_out_count", obs_q.size(), NP / 4);
    chk("frame_map_done_cnt", md_cnt, KM);
    run(NP, 3, 1'b0, 6);
    chk("frame_no_extra_out", obs_q.size(), NP / 4);

    // Reset mid-map (map 1, row 3, col 2) then a clean ramp.
    do_reset();
    run(MP + 3 * W + 2, 0, 1'b0, 0);
    do_reset();
    for (int i = 0; i < NP; i++) pix[i] = (i < MP) ? i : 0;
    run(MP, 0, 1'b1, 0);
    check_ramp("post_reset_out");
    chk("post_reset_frame_done", frame_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
